// File: rtl/fft_ctrl_if.sv
// Peripheral bus between the RS5 core and fft_ctrl: address, strobes, write data,
// and the one-cycle read response.
interface fft_ctrl_if #(
   parameter int unsigned DATA_WIDTH = 16
);
   logic [6:0]              bus_addr;
   logic                    bus_we;
   logic                    bus_re;
   logic [DATA_WIDTH-1:0]   bus_wdata;
   logic [2*DATA_WIDTH-1:0] bus_rdata;
   logic                    bus_rvalid;

   modport master (
      output bus_addr, bus_we, bus_re, bus_wdata,
      input  bus_rdata, bus_rvalid
   );

   modport slave (
      input  bus_addr, bus_we, bus_re, bus_wdata,
      output bus_rdata, bus_rvalid
   );
endinterface

// File: rtl/fft_ctrl.sv
// FFT accelerator sequencer: forwards sample writes, counts the settle latency after START,
// serves result/STATUS reads with one-cycle latency. FFT_CTRL_IRQ_EN adds the irq output.
module fft_ctrl #(
   parameter int unsigned ADDR_WIDTH = 5,
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned DEPTH      = 32,
   parameter int unsigned LATENCY    = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   fft_ctrl_if.slave               bus,
   output logic [ADDR_WIDTH-1:0]   m_addr,
   output logic [DATA_WIDTH-1:0]   m_data,
   output logic                    m_we,
   output logic [ADDR_WIDTH-1:0]   s_addr,
   output logic                    s_re,
   input  logic [2*DATA_WIDTH-1:0] s_data
`ifdef FFT_CTRL_IRQ_EN
   ,
   output logic                    irq
`endif
);

   localparam int unsigned CntW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   typedef enum logic [1:0] {StIdle, StLoad, StRun, StDone} state_e;

   state_e                  state_q, state_d;
   logic [DEPTH-1:0]        mask_q, mask_d;
   logic                    err_q, err_d;
   logic [CntW-1:0]         cnt_q, cnt_d;
   logic                    m_we_q, m_we_d;
   logic [ADDR_WIDTH-1:0]   m_addr_q, m_addr_d;
   logic [DATA_WIDTH-1:0]   m_data_q, m_data_d;
   logic                    rvalid_q, rvalid_d;
   logic                    rsel_q, rsel_d;
   logic [2*DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic [2*DATA_WIDTH-1:0] status;
   logic [7:0]              pop;
   logic                    irq_en;
   logic                    wr, rd, is_smp, is_res, is_ctrl, run;

   assign wr      = bus.bus_we;
   assign rd      = bus.bus_re & ~bus.bus_we;
   assign is_smp  = (bus.bus_addr[6:5] == 2'b00);
   assign is_res  = (bus.bus_addr[6:5] == 2'b01);
   assign is_ctrl = (bus.bus_addr == 7'h40);
   assign run     = (state_q == StRun);

   // Result reads go straight to the wrapper; its data returns on the next cycle.
   assign s_re   = rd & is_res & ~run;
   assign s_addr = s_re ? bus.bus_addr[ADDR_WIDTH-1:0] : '0;

   assign m_we           = m_we_q;
   assign m_addr         = m_addr_q;
   assign m_data         = m_data_q;
   assign bus.bus_rvalid = rvalid_q;
   assign bus.bus_rdata  = rsel_q ? s_data : rdata_q;

   always_comb begin
      pop = '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
         pop = pop + 8'(mask_q[i]);
      end
      status        = '0;
      status[13:8]  = pop[5:0];
      status[4]     = irq_en;
      status[3]     = &mask_q;
      status[2]     = err_q;
      status[1]     = (state_q == StDone);
      status[0]     = run;
   end

   always_comb begin
      state_d  = state_q;
      mask_d   = mask_q;
      err_d    = err_q;
      cnt_d    = cnt_q;
      m_we_d   = 1'b0;
      m_addr_d = m_addr_q;
      m_data_d = m_data_q;
      rvalid_d = rd;
      rsel_d   = 1'b0;
      rdata_d  = '0;

      if (run) begin
         if (cnt_q == '0) state_d = StDone;
         else             cnt_d   = cnt_q - 1'b1;
      end

      if (wr) begin
         if (is_smp) begin
            if (run) begin
               err_d = 1'b1;
            end else begin
               m_we_d   = 1'b1;
               m_addr_d = bus.bus_addr[ADDR_WIDTH-1:0];
               m_data_d = bus.bus_wdata;
               mask_d[bus.bus_addr[ADDR_WIDTH-1:0]] = 1'b1;
               state_d  = StLoad;
            end
         end else if (is_ctrl && !run) begin
            // CLEAR takes priority over START when both bits are set.
            if (bus.bus_wdata[1]) begin
               mask_d  = '0;
               err_d   = 1'b0;
               state_d = StIdle;
            end else if (bus.bus_wdata[0]) begin
               if (&mask_q) begin
                  state_d = StRun;
                  cnt_d   = CntW'(LATENCY - 1);
               end else begin
                  err_d = 1'b1;
               end
            end
         end
      end else if (rd) begin
         if (is_res) begin
            if (run) err_d  = 1'b1;
            else     rsel_d = 1'b1;
         end else if (is_ctrl) begin
            rdata_d = status;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= StIdle;
         mask_q   <= '0;
         err_q    <= 1'b0;
         cnt_q    <= '0;
         m_we_q   <= 1'b0;
         m_addr_q <= '0;
         m_data_q <= '0;
         rvalid_q <= 1'b0;
         rsel_q   <= 1'b0;
         rdata_q  <= '0;
      end else begin
         state_q  <= state_d;
         mask_q   <= mask_d;
         err_q    <= err_d;
         cnt_q    <= cnt_d;
         m_we_q   <= m_we_d;
         m_addr_q <= m_addr_d;
         m_data_q <= m_data_d;
         rvalid_q <= rvalid_d;
         rsel_q   <= rsel_d;
         rdata_q  <= rdata_d;
      end
   end

`ifdef FFT_CTRL_IRQ_EN
   logic irq_en_q, irq_en_d, irq_q;

   assign irq_en_d = (wr && is_ctrl) ? bus.bus_wdata[2] : irq_en_q;
   assign irq_en   = irq_en_q;
   assign irq      = irq_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         irq_en_q <= 1'b0;
         irq_q    <= 1'b0;
      end else begin
         irq_en_q <= irq_en_d;
         irq_q    <= (state_q == StDone) & irq_en_q;
      end
   end
`else
   assign irq_en = 1'b0;
`endif

endmodule

// File: tb/tb_fft_ctrl.sv
// Scoreboard bench for fft_ctrl: expected read data and wrapper writes are queued when
// stimulus is driven and compared when the DUT responds.
module tb_fft_ctrl;
   localparam int unsigned LAT = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   fft_ctrl_if #(.DATA_WIDTH(16)) bus_if ();

   logic [4:0]  m_addr;
   logic [15:0] m_data;
   logic        m_we;
   logic [4:0]  s_addr;
   logic        s_re;
   logic [31:0] s_data;
`ifdef FFT_CTRL_IRQ_EN
   logic        irq;
`endif

   fft_ctrl #(
      .ADDR_WIDTH(5),
      .DATA_WIDTH(16),
      .DEPTH     (32),
      .LATENCY   (LAT)
   ) u_dut (
      .clk   (clk),
      .rst   (rst),
      .bus   (bus_if),
      .m_addr(m_addr),
      .m_data(m_data),
      .m_we  (m_we),
      .s_addr(s_addr),
      .s_re  (s_re),
      .s_data(s_data)
`ifdef FFT_CTRL_IRQ_EN
      ,
      .irq   (irq)
`endif
   );

   // Wrapper model: register file written by the master port, registered slave read.
   logic [15:0] mem [32];
   always @(posedge clk) begin
      if (m_we) mem[m_addr] <= m_data;
      if (s_re) s_data <= {mem[s_addr], mem[s_addr] ^ 16'hA5A5};
   end

   logic [31:0] rd_q [$];
   logic [20:0] wr_q [$];
   int n_chk  = 0;
   int n_pass = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (bus_if.bus_rvalid) begin
            check_eq("rvalid_expected", 32'(rd_q.size() != 0), 32'd1);
            if (rd_q.size() != 0) check_eq("rdata", bus_if.bus_rdata, rd_q.pop_front());
         end
         if (m_we) begin
            check_eq("m_we_expected", 32'(wr_q.size() != 0), 32'd1);
            if (wr_q.size() != 0) check_eq("m_write", 32'({m_addr, m_data}), 32'(wr_q.pop_front()));
         end
      end
   end

   function automatic logic [31:0] st(input int pop, input bit full, input bit err,
                                      input bit done, input bit busy);
      logic [5:0] p;
      p = 6'(pop);
      return {18'b0, p, 3'b0, 1'b0, full, err, done, busy};
   endfunction

   task automatic cyc(input logic we, input logic re, input logic [6:0] a, input logic [15:0] d);
      bus_if.bus_we    = we;
      bus_if.bus_re    = re;
      bus_if.bus_addr  = a;
      bus_if.bus_wdata = d;
      @(negedge clk);
   endtask

   task automatic smp_wr(input int i, input logic [15:0] d, input bit accept);
      logic [4:0] a;
      a = 5'(i);
      if (accept) wr_q.push_back({a, d});
      cyc(1'b1, 1'b0, 7'(i), d);
   endtask

   task automatic bus_rd(input logic [6:0] a, input logic [31:0] exp);
      rd_q.push_back(exp);
      cyc(1'b0, 1'b1, a, 16'h0);
   endtask

   task automatic ctrl_wr(input logic [15:0] d);
      cyc(1'b1, 1'b0, 7'h40, d);
   endtask

   task automatic idle(input int n);
      repeat (n) cyc(1'b0, 1'b0, 7'h00, 16'h0);
   endtask

   initial begin
      #200_000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      bus_if.bus_we    = 1'b0;
      bus_if.bus_re    = 1'b0;
      bus_if.bus_addr  = 7'h00;
      bus_if.bus_wdata = 16'h0;
      @(negedge clk);
      @(negedge clk);
      check_eq("rst_m_we",   32'(m_we), 32'd0);
      check_eq("rst_m_addr", 32'(m_addr), 32'd0);
      check_eq("rst_m_data", 32'(m_data), 32'd0);
      check_eq("rst_s_re",   32'(s_re), 32'd0);
      check_eq("rst_rvalid", 32'(bus_if.bus_rvalid), 32'd0);
      check_eq("rst_rdata",  bus_if.bus_rdata, 32'd0);
      rst = 1'b0;

      bus_rd(7'h40, 32'h0);

      // Full load, START, status every cycle of the run, then result reads.
      for (int i = 0; i < 32; i++) smp_wr(i, 16'(i), 1'b1);
      ctrl_wr(16'h1);
      for (int k = 1; k <= int'(LAT); k++) bus_rd(7'h40, st(32, 1, 0, 0, 1));
      bus_rd(7'h40, st(32, 1, 0, 1, 0));
      bus_rd(7'h20, {16'h0000, 16'hA5A5});
      bus_rd(7'h27, {16'h0007, 16'h0007 ^ 16'hA5A5});
      ctrl_wr(16'h2);
      bus_rd(7'h40, 32'h0);

      // Partial load: START refused with ERR.
      for (int i = 0; i < 31; i++) smp_wr(i, 16'h100 + 16'(i), 1'b1);
      ctrl_wr(16'h1);
      bus_rd(7'h40, st(31, 0, 1, 0, 0));
      ctrl_wr(16'h3);
      bus_rd(7'h40, 32'h0);

      // Accesses during RUN: dropped write, blocked read, ignored START and CLEAR.
      for (int i = 0; i < 32; i++) smp_wr(i, 16'h200 + 16'(i), 1'b1);
      ctrl_wr(16'h1);
      smp_wr(5, 16'hDEAD, 1'b0);
      bus_rd(7'h25, 32'h0);
      ctrl_wr(16'h1);
      ctrl_wr(16'h2);
      for (int k = 5; k <= int'(LAT); k++) bus_rd(7'h40, st(32, 1, 1, 0, 1));
      bus_rd(7'h40, st(32, 1, 1, 1, 0));
      bus_rd(7'h25, {16'h0205, 16'h0205 ^ 16'hA5A5});
      ctrl_wr(16'h2);

      // Simultaneous write and read: write only. Unmapped reads return zero.
      wr_q.push_back({5'd3, 16'h0033});
      cyc(1'b1, 1'b1, 7'h03, 16'h0033);
      idle(2);
      bus_rd(7'h41, 32'h0);
      bus_rd(7'h7F, 32'h0);
      bus_rd(7'h40, st(1, 0, 0, 0, 0));

      // Reset mid-RUN aborts; no DONE afterwards.
      for (int i = 0; i < 32; i++) smp_wr(i, 16'h300 + 16'(i), 1'b1);
      ctrl_wr(16'h1);
      idle(3);
      #1 rst = 1'b1;
      #2 rst = 1'b0;
      @(negedge clk);
      bus_rd(7'h40, 32'h0);
      idle(int'(LAT) + 3);
      bus_rd(7'h40, 32'h0);

`ifdef FFT_CTRL_IRQ_EN
      ctrl_wr(16'h4);
      for (int i = 0; i < 32; i++) smp_wr(i, 16'(i), 1'b1);
      ctrl_wr(16'h1);
      idle(int'(LAT));
      check_eq("irq_at_done", 32'(irq), 32'd0);
      idle(1);
      check_eq("irq_after_done", 32'(irq), 32'd1);
      smp_wr(0, 16'h1, 1'b1);
      idle(1);
      check_eq("irq_dropped", 32'(irq), 32'd0);
`endif

      idle(3);
      check_eq("rd_q_drained", 32'(rd_q.size()), 32'd0);
      check_eq("wr_q_drained", 32'(wr_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
